// File: rtl/rf_pkg.sv
// Shared defaults and types for the multi-port register file with busy scoreboard.
package rf_pkg;

  localparam int unsigned RF_XLEN  = 32;
  localparam int unsigned RF_NREGS = 32;
  localparam int unsigned RF_AW    = $clog2(RF_NREGS);

  typedef logic [RF_AW-1:0]   reg_addr_t;
  typedef logic [RF_XLEN-1:0] xdata_t;

  localparam reg_addr_t REG_ZERO = '0;

endpackage

// File: rtl/rf_wr_resolve.sv
// Priority resolver: finds the highest-index enabled write port hitting one target address.
module rf_wr_resolve
  import rf_pkg::*;
#(
  parameter int unsigned XLEN = RF_XLEN,
  parameter int unsigned AW   = RF_AW,
  parameter int unsigned NWR  = 2
) (
  input  logic [AW-1:0]            addr,
  input  logic [NWR-1:0]           wr_en,
  input  logic [NWR-1:0][AW-1:0]   wr_addr,
  input  logic [NWR-1:0][XLEN-1:0] wr_data,
  output logic                     hit_c,
  output logic [XLEN-1:0]          data_c
);

  // Later ports overwrite earlier matches, so the highest index wins; x0 never hits.
  always_comb begin
    hit_c  = 1'b0;
    data_c = '0;
    for (int unsigned p = 0; p < NWR; p++) begin
      if (wr_en[p] && (wr_addr[p] == addr) && (addr != AW'(REG_ZERO))) begin
        hit_c  = 1'b1;
        data_c = wr_data[p];
      end
    end
  end

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-port integer register file with write-through bypass and a per-register busy scoreboard.
module regfile_mp_sb
  import rf_pkg::*;
#(
  parameter int unsigned XLEN  = RF_XLEN,
  parameter int unsigned NREGS = RF_NREGS,
  parameter int unsigned NRD   = 4,
  parameter int unsigned NWR   = 2,
  parameter int unsigned AW    = $clog2(NREGS)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NRD-1:0][AW-1:0]   rd_addr,
  output logic [NRD-1:0][XLEN-1:0] rd_data,
  output logic [NRD-1:0]           rd_busy,
  input  logic [NWR-1:0]           wr_en,
  input  logic [NWR-1:0][AW-1:0]   wr_addr,
  input  logic [NWR-1:0][XLEN-1:0] wr_data,
  input  logic                     iss_en,
  input  logic [AW-1:0]            iss_addr,
  input  logic                     flush,
  output logic [AW:0]              busy_cnt
);

  localparam int unsigned CW = AW + 1;

  logic [NREGS-1:0][XLEN-1:0] regs;
  logic [NREGS-1:0]           busy;
  logic [NREGS-1:0]           busy_nxt;
  logic [CW-1:0]              cnt_nxt;
  logic [NREGS-1:0]           w_hit;
  logic [NREGS-1:0][XLEN-1:0] w_data;
  logic [NRD-1:0]             rd_hit;
  logic [NRD-1:0][XLEN-1:0]   rd_byp;

  // Storage write decode: one resolver per architectural register.
  for (genvar r = 0; r < NREGS; r++) begin : g_wdec
    rf_wr_resolve #(.XLEN(XLEN), .AW(AW), .NWR(NWR)) u_wres (
      .addr    (AW'(r)),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .hit_c   (w_hit[r]),
      .data_c  (w_data[r])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      regs <= '0;
    end else begin
      for (int unsigned r = 0; r < NREGS; r++) begin
        if (w_hit[r]) regs[r] <= w_data[r];
      end
    end
  end

  // Scoreboard next state: flush > issue > write-back > hold; count tracks set/clear deltas.
  always_comb begin
    busy_nxt = busy;
    cnt_nxt  = busy_cnt;
    for (int unsigned r = 1; r < NREGS; r++) begin
      if (flush)                                  busy_nxt[r] = 1'b0;
      else if (iss_en && (iss_addr == AW'(r)))    busy_nxt[r] = 1'b1;
      else if (w_hit[r])                          busy_nxt[r] = 1'b0;
    end
    busy_nxt[0] = 1'b0;
    for (int unsigned r = 1; r < NREGS; r++) begin
      if (busy_nxt[r] && !busy[r])      cnt_nxt = cnt_nxt + CW'(1);
      else if (!busy_nxt[r] && busy[r]) cnt_nxt = cnt_nxt - CW'(1);
    end
    if (flush) cnt_nxt = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy     <= '0;
      busy_cnt <= '0;
    end else begin
      busy     <= busy_nxt;
      busy_cnt <= cnt_nxt;
    end
  end

  // Read ports: same-cycle write-through, busy shows clears but not a new issue.
  for (genvar i = 0; i < NRD; i++) begin : g_rd
    rf_wr_resolve #(.XLEN(XLEN), .AW(AW), .NWR(NWR)) u_byp (
      .addr    (rd_addr[i]),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .hit_c   (rd_hit[i]),
      .data_c  (rd_byp[i])
    );

    assign rd_data[i] = (reset || (rd_addr[i] == AW'(REG_ZERO))) ? '0 :
                        rd_hit[i] ? rd_byp[i] : regs[rd_addr[i]];
    assign rd_busy[i] = (reset || (rd_addr[i] == AW'(REG_ZERO)) || rd_hit[i] || flush) ? 1'b0 :
                        busy[rd_addr[i]];
  end

endmodule
